// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported word memory.
// One access in flight; data has priority until fetch has lost STARVE_MAX times.
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_valid,
  output logic [31:0]       f_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, F_ACC, D_ACC} state_t;

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t        state_reg;
  logic [SW-1:0] starve_reg;
  logic          store_reg;
  logic [31:0]   f_data_reg;
  logic [31:0]   d_rdata_reg;
  logic          grant_f;
  logic          grant_d;

  // Grants are decided in the IDLE cycle itself so the memory strobe goes out that cycle.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (!rst && state_reg == IDLE) begin
      if (f_req && (!d_req || starve_reg == STARVE_TOP))
        grant_f = 1'b1;
      else if (d_req)
        grant_d = 1'b1;
    end
  end

  assign mem_en    = grant_f | grant_d;
  assign mem_we    = (grant_d && d_we) ? d_be : 4'b0000;
  assign mem_addr  = grant_f ? (f_addr & ALIGN_MASK) :
                     grant_d ? (d_addr & ALIGN_MASK) : '0;
  assign mem_wdata = grant_d ? d_wdata : 32'h0;

  assign busy    = (state_reg != IDLE);
  assign f_valid = (state_reg == F_ACC);
  assign d_valid = (state_reg == D_ACC);
  // Memory read data arrives in the access cycle; hold registers keep it afterwards.
  assign f_data  = f_valid ? mem_rdata : f_data_reg;
  assign d_rdata = d_valid ? (store_reg ? 32'h0 : mem_rdata) : d_rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      starve_reg  <= '0;
      store_reg   <= 1'b0;
      f_data_reg  <= 32'h0;
      d_rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_f) begin
            state_reg  <= F_ACC;
            starve_reg <= '0;
          end else if (grant_d) begin
            state_reg <= D_ACC;
            store_reg <= d_we;
            if (f_req && starve_reg != STARVE_TOP)
              starve_reg <= starve_reg + SW'(1);
          end
        end
        F_ACC: begin
          f_data_reg <= mem_rdata;
          state_reg  <= IDLE;
        end
        D_ACC: begin
          d_rdata_reg <= store_reg ? 32'h0 : mem_rdata;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we;
  logic [11:0] f_addr, d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        f_valid, d_valid, mem_en, busy;
  logic [31:0] f_data, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_arr   [1024];
  logic [31:0] model_mem [1024];

  mem_arbiter #(.ADDR_W(12), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Word memory with a registered read port and byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_arr[mem_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem_arr[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: 0 = nothing pending, 1 = fetch, 2 = data.
  int          m_pend   = 0;
  int          m_starve = 0;
  logic [31:0] m_data;
  logic [31:0] m_last_f = 32'h0;
  logic [31:0] m_last_d = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      m_pend = 0; m_starve = 0; m_last_f = 32'h0; m_last_d = 32'h0;
      chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
      chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", {20'b0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_valids", {30'b0, f_valid, d_valid}, 32'h0);
      chk("rst_f_data", f_data, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
    end else if (m_pend != 0) begin
      chk("acc_busy", {31'b0, busy}, 32'h1);
      chk("acc_mem_en", {31'b0, mem_en}, 32'h0);
      chk("acc_mem_we", {28'b0, mem_we}, 32'h0);
      chk("acc_f_valid", {31'b0, f_valid}, (m_pend == 1) ? 32'h1 : 32'h0);
      chk("acc_d_valid", {31'b0, d_valid}, (m_pend == 2) ? 32'h1 : 32'h0);
      if (m_pend == 1) begin
        m_last_f = m_data;
        $display("txn fetch data=%h", m_data);
      end else begin
        m_last_d = m_data;
        $display("txn data  rdata=%h", m_data);
      end
      chk("f_data", f_data, m_last_f);
      chk("d_rdata", d_rdata, m_last_d);
      m_pend = 0;
    end else begin
      int win;
      chk("idle_busy", {31'b0, busy}, 32'h0);
      chk("idle_valids", {30'b0, f_valid, d_valid}, 32'h0);
      chk("hold_f_data", f_data, m_last_f);
      chk("hold_d_rdata", d_rdata, m_last_d);
      win = 0;
      if (f_req && d_req) begin
        if (m_starve == 3) begin win = 1; m_starve = 0; end
        else begin win = 2; m_starve++; end
      end else if (f_req) begin
        win = 1; m_starve = 0;
      end else if (d_req) begin
        win = 2;
      end
      if (win == 0) begin
        chk("idle_mem_en", {31'b0, mem_en}, 32'h0);
        chk("idle_mem_we", {28'b0, mem_we}, 32'h0);
      end else if (win == 1) begin
        chk("gnt_f_en", {31'b0, mem_en}, 32'h1);
        chk("gnt_f_we", {28'b0, mem_we}, 32'h0);
        chk("gnt_f_addr", {20'b0, mem_addr}, {20'b0, f_addr & 12'hFFC});
        m_data = model_mem[f_addr >> 2];
      end else begin
        int w;
        w = int'(d_addr >> 2);
        chk("gnt_d_en", {31'b0, mem_en}, 32'h1);
        chk("gnt_d_we", {28'b0, mem_we}, d_we ? {28'b0, d_be} : 32'h0);
        chk("gnt_d_addr", {20'b0, mem_addr}, {20'b0, d_addr & 12'hFFC});
        chk("gnt_d_wdata", mem_wdata, d_wdata);
        if (d_we) begin
          m_data = 32'h0;
          for (int b = 0; b < 4; b++)
            if (d_be[b]) model_mem[w][b*8 +: 8] = d_wdata[b*8 +: 8];
        end else begin
          m_data = model_mem[w];
        end
      end
      m_pend = win;
    end
  end

  initial begin
    logic [31:0] v;
    string       order;
    int          nval, gap, maxgap, fw, dw;
    logic        fv, dv;

    rst = 1'b1; f_req = 0; d_req = 0; d_we = 0; d_be = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom; mem_arr[i] = v; model_mem[i] = v;
    end
    mem_arr[2] = 32'h00000013;   model_mem[2] = 32'h00000013;
    mem_arr[4] = 32'hCAFE0010;   model_mem[4] = 32'hCAFE0010;
    mem_arr[3] = 32'h11223344;   model_mem[3] = 32'h11223344;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Aligned fetch of word 2.
    @(posedge clk); #1; f_req = 1; f_addr = 12'h008;
    @(negedge clk);
    chk("fetch_en", {31'b0, mem_en}, 32'h1);
    chk("fetch_addr", {20'b0, mem_addr}, 32'h008);
    @(negedge clk);
    chk("fetch_valid", {31'b0, f_valid}, 32'h1);
    chk("fetch_data", f_data, 32'h00000013);
    @(posedge clk); #1; f_req = 0;

    // Single-byte store into lane 2 of word 3, then load it back.
    @(posedge clk); #1; d_req = 1; d_we = 1; d_be = 4'b0100; d_addr = 12'h00E; d_wdata = 32'h00AB0000;
    @(negedge clk);
    chk("store_we", {28'b0, mem_we}, 32'h4);
    chk("store_addr", {20'b0, mem_addr}, 32'h00C);
    @(negedge clk);
    chk("store_valid", {31'b0, d_valid}, 32'h1);
    chk("store_rdata", d_rdata, 32'h0);
    @(posedge clk); #1; d_we = 0; d_be = 0; d_addr = 12'h00C; d_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("load_valid", {31'b0, d_valid}, 32'h1);
    chk("load_word", d_rdata, 32'h11AB3344);
    @(posedge clk); #1; d_req = 0;

    // Misaligned fetch returns the enclosing word.
    @(posedge clk); #1; f_req = 1; f_addr = 12'h013;
    @(negedge clk);
    chk("misal_addr", {20'b0, mem_addr}, 32'h010);
    @(negedge clk);
    chk("misal_data", f_data, 32'hCAFE0010);
    @(posedge clk); #1; f_req = 0;

    // Both requesters held continuously.
    @(posedge clk); #1; f_req = 1; f_addr = 12'h020; d_req = 1; d_we = 0; d_addr = 12'h024;
    order = ""; nval = 0; gap = 0; maxgap = 0;
    for (int c = 0; c < 40 && nval < 8; c++) begin
      @(negedge clk);
      gap++;
      if (f_valid) begin order = {order, "F"}; nval++; if (gap > maxgap) maxgap = gap; gap = 0; end
      if (d_valid) begin order = {order, "D"}; nval++; end
    end
    total++;
    if (order != "DDDFDDDF") begin
      bad++;
      $display("FAIL grant_order actual=%s required=DDDFDDDF", order);
    end
    chk("fetch_gap_le8", {31'b0, maxgap <= 8}, 32'h1);
    @(posedge clk); #1; f_req = 0; d_req = 0;

    // Reset during the access cycle of a store aborts its completion.
    @(posedge clk); #1; d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 12'h040; d_wdata = $urandom;
    v = d_wdata;
    @(posedge clk); #2; rst = 1;
    #1;
    chk("abort_d_valid", {31'b0, d_valid}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_mem_en", {31'b0, mem_en}, 32'h0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    d_req = 0; d_we = 0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1; f_req = 1; f_addr = 12'h040;
    @(negedge clk);
    chk("post_rst_en", {31'b0, mem_en}, 32'h1);
    @(negedge clk);
    chk("post_rst_valid", {31'b0, f_valid}, 32'h1);
    chk("post_rst_data", f_data, v);
    @(posedge clk); #1; f_req = 0;

    // Randomized traffic; the model process checks every cycle.
    fw = 0; dw = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fv = f_valid; dv = d_valid;
      if (f_req) fw++;
      if (d_req) dw++;
      if (fv) begin chk("f_wait_le9", {31'b0, fw <= 9}, 32'h1); fw = 0; end
      if (dv) begin chk("d_wait_le5", {31'b0, dw <= 5}, 32'h1); dw = 0; end
      @(posedge clk); #1;
      if (!f_req || fv) begin
        f_req = $urandom_range(0, 1); f_addr = 12'($urandom_range(0, 255));
      end
      if (!d_req || dv) begin
        d_req = $urandom_range(0, 1); d_we = $urandom_range(0, 1);
        d_be = 4'($urandom); d_addr = 12'($urandom_range(0, 255)); d_wdata = $urandom;
      end
    end
    // Let any outstanding access complete, then go idle.
    for (int c = 0; c < 12 && (f_req || d_req); c++) begin
      @(negedge clk); fv = f_valid; dv = d_valid;
      @(posedge clk); #1;
      if (fv) f_req = 0;
      if (dv) d_req = 0;
    end
    f_req = 0; d_req = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
